sudoku_solve_scheduler: RTL and testbench

SUDOKU_SOLVE_SCHEDULER -- requirements
Module: sudoku_solve_scheduler

---
 rtl/sudoku_sched_pkg.sv | 40 ++++
 rtl/sudoku_slot_seq.sv | 137 +++++++++++++
 rtl/sudoku_solve_scheduler.sv | 152 +++++++++++++++
 tb/tb_sudoku_solve_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_sched_pkg.sv
// Shared definitions for the sudoku solve scheduler.
//   slot_state_e : per-slot sequencer state
//   CODE_*       : result codes reported on res_code_o
//   job_t        : one entry of the job FIFO
package sudoku_sched_pkg;

  localparam int NUM_SLOTS = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_RUN    = 3'd2,
    ST_ABORT  = 3'd3,
    ST_REPORT = 3'd4
  } slot_state_e;

  localparam logic [2:0] CODE_SOLVED  = 3'd0;
  localparam logic [2:0] CODE_STUCK   = 3'd1;
  localparam logic [2:0] CODE_ILLEGAL = 3'd2;
  localparam logic [2:0] CODE_TIMEOUT = 3'd3;
  localparam logic [2:0] CODE_ABORTED = 3'd4;

  typedef struct packed {
    logic       slot;
    logic [3:0] tag;
    logic       naked;
  } job_t;

  // Completion code from solver flags: illegal beats solved beats stuck;
  // a drop of busy with no flag at all is treated as stuck.
  function automatic logic [2:0] result_code(input logic solved,
                                             input logic stuck,
                                             input logic illegal);
    if (illegal)     return CODE_ILLEGAL;
    else if (solved) return CODE_SOLVED;
    else if (stuck)  return CODE_STUCK;
    else             return CODE_STUCK;
  endfunction

endpackage

// File: rtl/sudoku_slot_seq.sv
// Per-solver sequencer: starts one job on its solver, supervises it with a
// cycle timer, retries a stuck attempt once with allow_naked set, handles
// software abort, and holds the result until the arbiter takes it.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   dispatch_i            take job (tag_i, naked_i) this cycle (only while idle)
//   abort_req_i           software abort pulse
//   busy/solved/stuck/illegal_i  solver status
//   grant_i               result transferred this cycle
//   idle_o, report_o      state decodes for the dispatcher / arbiter
//   start_o, abort_o, allow_naked_o  solver controls
//   tag_o, code_o, retried_o         result fields
module sudoku_slot_seq
  import sudoku_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 50000,
  parameter bit          RETRY_NAKED = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dispatch_i,
  input  logic [3:0] tag_i,
  input  logic       naked_i,
  input  logic       abort_req_i,
  input  logic       busy_i,
  input  logic       solved_i,
  input  logic       stuck_i,
  input  logic       illegal_i,
  input  logic       grant_i,
  output logic       idle_o,
  output logic       report_o,
  output logic       start_o,
  output logic       abort_o,
  output logic       allow_naked_o,
  output logic [3:0] tag_o,
  output logic [2:0] code_o,
  output logic       retried_o
);

  // Timer value on the last permitted cycle of an attempt.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  slot_state_e state_q, state_d;
  logic [3:0]  tag_q, tag_d;
  logic        naked_q, naked_d;
  logic        retried_q, retried_d;
  logic [2:0]  code_q, code_d;
  logic [15:0] timer_q, timer_d;

  logic       timeout_hit;
  logic [2:0] result;

  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMO_LAST);
  assign result      = result_code(solved_i, stuck_i, illegal_i);

  // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    naked_d   = naked_q;
    retried_d = retried_q;
    code_d    = code_q;
    timer_d   = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dispatch_i) begin
          state_d   = ST_START;
          tag_d     = tag_i;
          naked_d   = naked_i;
          retried_d = 1'b0;
          timer_d   = '0;
        end
      end
      ST_START, ST_RUN: begin
        timer_d = timer_q + 16'd1;
        // Software abort outranks the timeout, which outranks completion.
        if (abort_req_i) begin
          state_d = ST_ABORT;
          code_d  = CODE_ABORTED;
        end else if (timeout_hit) begin
          state_d = ST_ABORT;
          code_d  = CODE_TIMEOUT;
        end else if (state_q == ST_START) begin
          if (busy_i) state_d = ST_RUN;
        end else if (!busy_i) begin
          if (result == CODE_STUCK && !naked_q && RETRY_NAKED && !retried_q) begin
            state_d   = ST_START;
            naked_d   = 1'b1;
            retried_d = 1'b1;
            timer_d   = '0;
          end else begin
            state_d = ST_REPORT;
            code_d  = result;
          end
        end
      end
      ST_ABORT: begin
        if (!busy_i) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (grant_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tag_q     <= '0;
      naked_q   <= 1'b1;
      retried_q <= 1'b0;
      code_q    <= CODE_SOLVED;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      naked_q   <= naked_d;
      retried_q <= retried_d;
      code_q    <= code_d;
      timer_q   <= timer_d;
    end
  end

  // Controls decode straight from the state register: start and abort are
  // glitch-free and can never be high together.
  assign idle_o        = (state_q == ST_IDLE);
  assign report_o      = (state_q == ST_REPORT);
  assign start_o       = (state_q == ST_START);
  assign abort_o       = (state_q == ST_ABORT);
  assign allow_naked_o = naked_q;
  assign tag_o         = tag_q;
  assign code_o        = code_q;
  assign retried_o     = retried_q;

endmodule

// File: rtl/sudoku_solve_scheduler.sv
// Schedules sudoku jobs onto two solver slots. Jobs enter an in-order FIFO;
// the head job goes to its target slot when that slot is idle (head-of-line
// blocking, no reordering). Results from the two slots are merged onto one
// result port by a round-robin arbiter.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   job_*                   job enqueue handshake and fields
//   res_*                   result handshake and fields
//   abort_req_i[1:0]        per-slot software abort pulse
//   slv_*_o[1:0]            per-solver start/abort/allow_naked
//   slv_*_i[1:0]            per-solver busy/solved/stuck/illegal
//   queue_count_o           FIFO occupancy
//   sched_busy_o            any slot active or FIFO non-empty
module sudoku_solve_scheduler
  import sudoku_sched_pkg::*;
#(
  parameter int unsigned JOB_DEPTH   = 4,
  parameter int unsigned TIMEOUT     = 50000,
  parameter bit          RETRY_NAKED = 1'b1
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic                       job_slot_i,
  input  logic [3:0]                 job_tag_i,
  input  logic                       job_naked_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic                       res_slot_o,
  output logic [3:0]                 res_tag_o,
  output logic [2:0]                 res_code_o,
  output logic                       res_retried_o,
  input  logic [1:0]                 abort_req_i,
  output logic [1:0]                 slv_start_o,
  output logic [1:0]                 slv_abort_o,
  output logic [1:0]                 slv_allow_naked_o,
  input  logic [1:0]                 slv_busy_i,
  input  logic [1:0]                 slv_solved_i,
  input  logic [1:0]                 slv_stuck_i,
  input  logic [1:0]                 slv_illegal_i,
  output logic [$clog2(JOB_DEPTH):0] queue_count_o,
  output logic                       sched_busy_o
);

  localparam int          AW        = $clog2(JOB_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(JOB_DEPTH);

  // ---------------- job FIFO ----------------
  job_t          fifo_mem [JOB_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          fifo_full, fifo_empty, enq, deq;
  job_t          job_in, head;

  logic [NUM_SLOTS-1:0] slot_idle, slot_report, dispatch, grant;
  logic [3:0]           slot_tag  [NUM_SLOTS];
  logic [2:0]           slot_code [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_retried;

  assign fifo_full   = (count_q == DEPTH_CNT);
  assign fifo_empty  = (count_q == '0);
  assign job_ready_o = !fifo_full && !wb_rst_i;
  assign enq         = job_valid_i && job_ready_o;
  assign deq         = |dispatch;
  assign job_in      = '{slot: job_slot_i, tag: job_tag_i, naked: job_naked_i};
  assign head        = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (enq) fifo_mem[wr_ptr_q] <= job_in;
  end

  assign queue_count_o = count_q;

  // ---------------- result arbiter ----------------
  logic last_q;     // slot served most recently
  logic grant_idx;
  logic transfer;

  // With both slots reporting, serve the one not served last.
  assign grant_idx   = (&slot_report) ? ~last_q : slot_report[1];
  assign res_valid_o = |slot_report;
  assign transfer    = res_valid_o && res_ready_i;

  assign res_slot_o    = grant_idx;
  assign res_tag_o     = slot_tag[grant_idx];
  assign res_code_o    = slot_code[grant_idx];
  assign res_retried_o = slot_retried[grant_idx];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)      last_q <= 1'b0;
    else if (transfer) last_q <= grant_idx;
  end

  // ---------------- slots ----------------
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    // Dispatch looks at the registered idle state, so a slot leaving
    // REPORT always spends one cycle in IDLE before taking a new job.
    assign dispatch[s] = !fifo_empty && (head.slot == 1'(s)) && slot_idle[s];
    assign grant[s]    = transfer && (grant_idx == 1'(s));

    sudoku_slot_seq #(
      .TIMEOUT     (TIMEOUT),
      .RETRY_NAKED (RETRY_NAKED)
    ) u_seq (
      .clk_i         (wb_clk_i),
      .rst_i         (wb_rst_i),
      .dispatch_i    (dispatch[s]),
      .tag_i         (head.tag),
      .naked_i       (head.naked),
      .abort_req_i   (abort_req_i[s]),
      .busy_i        (slv_busy_i[s]),
      .solved_i      (slv_solved_i[s]),
      .stuck_i       (slv_stuck_i[s]),
      .illegal_i     (slv_illegal_i[s]),
      .grant_i       (grant[s]),
      .idle_o        (slot_idle[s]),
      .report_o      (slot_report[s]),
      .start_o       (slv_start_o[s]),
      .abort_o       (slv_abort_o[s]),
      .allow_naked_o (slv_allow_naked_o[s]),
      .tag_o         (slot_tag[s]),
      .code_o        (slot_code[s]),
      .retried_o     (slot_retried[s])
    );
  end

  assign sched_busy_o = !(&slot_idle) || !fifo_empty;

endmodule

// File: tb/tb_sudoku_solve_scheduler.sv
// Directed bench for sudoku_solve_scheduler (JOB_DEPTH=4, TIMEOUT=20).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sudoku_solve_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       job_valid, job_ready, job_slot, job_naked;
  logic [3:0] job_tag;
  logic       res_valid, res_ready, res_slot, res_retried;
  logic [3:0] res_tag;
  logic [2:0] res_code;
  logic [1:0] abort_req, slv_start, slv_abort, slv_allow_naked;
  logic [1:0] slv_busy, slv_solved, slv_stuck, slv_illegal;
  logic [2:0] queue_count;
  logic       sched_busy;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  sudoku_solve_scheduler #(
    .JOB_DEPTH   (4),
    .TIMEOUT     (20),
    .RETRY_NAKED (1'b1)
  ) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .job_valid_i       (job_valid),
    .job_ready_o       (job_ready),
    .job_slot_i        (job_slot),
    .job_tag_i         (job_tag),
    .job_naked_i       (job_naked),
    .res_valid_o       (res_valid),
    .res_ready_i       (res_ready),
    .res_slot_o        (res_slot),
    .res_tag_o         (res_tag),
    .res_code_o        (res_code),
    .res_retried_o     (res_retried),
    .abort_req_i       (abort_req),
    .slv_start_o       (slv_start),
    .slv_abort_o       (slv_abort),
    .slv_allow_naked_o (slv_allow_naked),
    .slv_busy_i        (slv_busy),
    .slv_solved_i      (slv_solved),
    .slv_stuck_i       (slv_stuck),
    .slv_illegal_i     (slv_illegal),
    .queue_count_o     (queue_count),
    .sched_busy_o      (sched_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_job_ready"},   job_ready,       0);
    check({pfx, "_queue_count"}, queue_count,     0);
    check({pfx, "_res_valid"},   res_valid,       0);
    check({pfx, "_slv_start"},   slv_start,       0);
    check({pfx, "_slv_abort"},   slv_abort,       0);
    check({pfx, "_allow_naked"}, slv_allow_naked, 2'b11);
    check({pfx, "_sched_busy"},  sched_busy,      0);
  endtask

  initial begin
    rst = 1'b1; job_valid = 0; job_slot = 0; job_tag = 0; job_naked = 0;
    res_ready = 0; abort_req = 0; slv_busy = 0; slv_solved = 0;
    slv_stuck = 0; slv_illegal = 0;

    // ---- reset ----
    step(2);
    check_reset_outputs("rst");
    rst = 1'b0;
    step(1);
    check("ready_after_reset", job_ready, 1);

    // ---- both slots finish together: slot1 first, then slot0 ----
    job_valid = 1; job_slot = 0; job_tag = 4'd1; job_naked = 1;
    step(1);
    job_slot = 1; job_tag = 4'd2;
    step(1);
    check("rr_simul_enq_deq_count", queue_count, 1);
    check("rr_start_slot0", slv_start, 2'b01);
    job_valid = 0; slv_busy = 2'b01;
    step(1);
    check("rr_start_slot1", slv_start, 2'b10);
    check("rr_queue_empty", queue_count, 0);
    check("rr_allow_naked", slv_allow_naked, 2'b11);
    slv_busy = 2'b11;
    step(1);
    slv_busy = 2'b00; slv_solved = 2'b11; res_ready = 1;
    step(1);
    check("rr_first_valid", res_valid, 1);
    check("rr_first_slot", res_slot, 1);
    check("rr_first_tag", res_tag, 2);
    check("rr_first_code", res_code, 0);
    slv_solved = 0;
    step(1);
    check("rr_second_valid", res_valid, 1);
    check("rr_second_slot", res_slot, 0);
    check("rr_second_tag", res_tag, 1);
    step(1);
    check("rr_drained", res_valid, 0);
    res_ready = 0;

    // ---- slot0 tag5, busy 3 cycles then solved ----
    job_valid = 1; job_slot = 0; job_tag = 4'd5; job_naked = 0;
    step(1);
    check("a_enq_count", queue_count, 1);
    job_valid = 0;
    step(1);
    check("a_start", slv_start, 2'b01);
    check("a_allow_naked0", slv_allow_naked[0], 0);
    slv_busy = 2'b01;
    step(1);
    check("a_start_dropped", slv_start, 0);
    step(2);
    slv_busy = 0; slv_solved = 2'b01;
    step(1);
    check("a_res_valid", res_valid, 1);
    check("a_res_slot", res_slot, 0);
    check("a_res_tag", res_tag, 5);
    check("a_res_code", res_code, 0);
    check("a_res_retried", res_retried, 0);
    slv_solved = 0;
    step(1);
    check("a_res_hold", res_valid, 1);
    res_ready = 1;
    step(1);
    check("a_res_taken", res_valid, 0);
    check("a_sched_idle", sched_busy, 0);
    res_ready = 0;

    // ---- slot1 stuck, retried with allow_naked, then solved ----
    job_valid = 1; job_slot = 1; job_tag = 4'd9; job_naked = 0;
    step(1);
    job_valid = 0;
    step(1);
    check("b_start", slv_start, 2'b10);
    check("b_allow_naked1_first", slv_allow_naked[1], 0);
    slv_busy = 2'b10;
    step(1);
    slv_busy = 0; slv_stuck = 2'b10;
    step(1);
    check("b_restart", slv_start, 2'b10);
    check("b_allow_naked1_retry", slv_allow_naked[1], 1);
    check("b_no_result_yet", res_valid, 0);
    slv_stuck = 0; slv_busy = 2'b10;
    step(1);
    slv_busy = 0; slv_solved = 2'b10;
    step(1);
    check("b_res_slot", res_slot, 1);
    check("b_res_tag", res_tag, 9);
    check("b_res_code", res_code, 0);
    check("b_res_retried", res_retried, 1);
    slv_solved = 0; res_ready = 1;
    step(1);
    check("b_res_taken", res_valid, 0);
    res_ready = 0;

    // ---- illegal beats solved ----
    job_valid = 1; job_slot = 1; job_tag = 4'd7; job_naked = 1;
    step(1);
    job_valid = 0;
    step(1);
    slv_busy = 2'b10;
    step(1);
    slv_busy = 0; slv_illegal = 2'b10; slv_solved = 2'b10;
    step(1);
    check("ill_res_code", res_code, 2);
    check("ill_res_retried", res_retried, 0);
    slv_illegal = 0; slv_solved = 0; res_ready = 1;
    step(1);
    res_ready = 0;

    // ---- stuck with naked already set: no retry, code 1 ----
    job_valid = 1; job_slot = 0; job_tag = 4'd6; job_naked = 1;
    step(1);
    job_valid = 0;
    step(1);
    slv_busy = 2'b01;
    step(1);
    slv_busy = 0; slv_stuck = 2'b01;
    step(1);
    check("stk_res_valid", res_valid, 1);
    check("stk_res_code", res_code, 1);
    check("stk_res_retried", res_retried, 0);
    slv_stuck = 0; res_ready = 1;
    step(1);
    res_ready = 0;

    // ---- timeout: busy held high ----
    job_valid = 1; job_slot = 0; job_tag = 4'd3; job_naked = 1;
    step(1);
    job_valid = 0;
    step(1);
    slv_busy = 2'b01;
    cnt = 0;
    while (slv_abort[0] !== 1'b1 && cnt < 40) begin
      cnt++;
      step(1);
    end
    check("tmo_attempt_cycles", cnt, 20);
    check("tmo_abort", slv_abort, 2'b01);
    check("tmo_no_start", slv_start, 0);
    step(1);
    check("tmo_abort_held", slv_abort, 2'b01);
    slv_busy = 0;
    step(1);
    check("tmo_res_valid", res_valid, 1);
    check("tmo_res_code", res_code, 3);
    check("tmo_res_tag", res_tag, 3);
    res_ready = 1;
    step(1);
    res_ready = 0;

    // ---- fill FIFO, software abort, reset mid-run ----
    for (int i = 0; i < 5; i++) begin
      check("fill_ready", job_ready, 1);
      job_valid = 1; job_slot = 0; job_tag = 4'(i + 1); job_naked = 1;
      step(1);
    end
    check("full_ready", job_ready, 0);
    check("full_count", queue_count, 4);
    job_tag = 4'd6; slv_busy = 2'b01;
    step(1);
    check("full_blocks_enq", queue_count, 4);
    job_valid = 0; abort_req = 2'b01;
    step(1);
    check("abt_abort", slv_abort, 2'b01);
    check("abt_no_start", slv_start, 0);
    abort_req = 0; slv_busy = 0;
    step(1);
    check("abt_res_code", res_code, 4);
    check("abt_res_tag", res_tag, 1);
    res_ready = 1;
    step(1);
    check("abt_res_taken", res_valid, 0);
    check("idle_gap_no_dispatch", slv_start, 0);
    check("idle_gap_count", queue_count, 4);
    res_ready = 0;
    step(1);
    check("next_dispatch_start", slv_start, 2'b01);
    check("next_dispatch_count", queue_count, 3);
    slv_busy = 2'b01;
    step(1);
    rst = 1;
    step(1);
    check_reset_outputs("midrst");
    rst = 0; slv_busy = 0;
    step(1);
    check("post_rst_ready", job_ready, 1);
    check("post_rst_busy", sched_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
